uart_tx_scheduler: RTL

//   Round-robin scheduler sharing one uart_tx instance among NUM_REQ byte producers.

---
 rtl/uart_tx_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte producers,
// with an inter-frame gap and a watchdog that aborts a transmitter that never reports done.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 87,
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic [NUM_REQ-1:0]     i_Req,
  input  logic [8*NUM_REQ-1:0]   i_Byte,
  output logic [NUM_REQ-1:0]     o_Ack,
  output logic [NUM_REQ-1:0]     o_Done,
  output logic                   o_Timeout,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic [1:0]             o_Dbg_State
);

  // Handshake: a requester raises i_Req[k] with i_Byte[k] valid and holds both
  // until o_Ack[k]; the byte is captured on the edge that raises o_Ack[k]. A request
  // still high after its ack is a fresh request. o_Done[k] closes that frame.

  localparam int PW   = $clog2(NUM_REQ);
  localparam int CMAX = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, GAP} state_t;

  state_t               state, state_next;
  logic [PW-1:0]        ptr, ptr_next;
  logic [PW-1:0]        sel, sel_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [7:0]           tx_byte_next;
  logic [NUM_REQ-1:0]   ack_next, done_next;
  logic                 timeout_next, tx_dv_next;

  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;
  int                   idx_i;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    idx_i = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_i = int'(ptr) + i;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = PW'(idx_i);
      if (!found && i_Req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    sel_next     = sel;
    cnt_next     = cnt;
    tx_byte_next = o_Tx_Byte;
    ack_next     = '0;
    done_next    = '0;
    timeout_next = 1'b0;
    tx_dv_next   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !i_Tx_Active) begin
          sel_next      = win;
          tx_byte_next  = i_Byte[{win, 3'b000} +: 8];
          ack_next[win] = 1'b1;
          ptr_next      = (win == PTR_LAST) ? '0 : win + PW'(1);
          state_next    = LOAD;
        end
      end
      LOAD: begin
        tx_dv_next = 1'b1;
        cnt_next   = '0;
        state_next = BUSY;
      end
      BUSY: begin
        // Done takes priority over a coincident watchdog expiry.
        if (i_Tx_Done) begin
          done_next[sel] = 1'b1;
          cnt_next       = '0;
          state_next     = GAP;
        end else if (cnt == TO_LAST) begin
          timeout_next = 1'b1;
          cnt_next     = '0;
          state_next   = GAP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      o_Tx_Byte <= 8'h00;
      o_Ack     <= '0;
      o_Done    <= '0;
      o_Timeout <= 1'b0;
      o_Tx_DV   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      sel       <= sel_next;
      cnt       <= cnt_next;
      o_Tx_Byte <= tx_byte_next;
      o_Ack     <= ack_next;
      o_Done    <= done_next;
      o_Timeout <= timeout_next;
      o_Tx_DV   <= tx_dv_next;
    end
  end

  assign o_Busy      = (state != IDLE);
  assign o_Dbg_State = state;

endmodule
